// File: rtl/mem_stage_pkg.sv
// Purpose: shared widths, memory-op and FSM encodings for the MEM pipeline stage.
// Latency: n/a (types and helper functions only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int REG_ADDR_BUS = 5;
    localparam int REG_BUS      = 32;
    localparam int MEM_OP_BUS   = 4;

    localparam logic [MEM_OP_BUS-1:0] MEM_NOP = 4'd0;
    localparam logic [MEM_OP_BUS-1:0] MEM_LB  = 4'd1;
    localparam logic [MEM_OP_BUS-1:0] MEM_LH  = 4'd2;
    localparam logic [MEM_OP_BUS-1:0] MEM_LW  = 4'd3;
    localparam logic [MEM_OP_BUS-1:0] MEM_LBU = 4'd4;
    localparam logic [MEM_OP_BUS-1:0] MEM_LHU = 4'd5;
    localparam logic [MEM_OP_BUS-1:0] MEM_SB  = 4'd6;
    localparam logic [MEM_OP_BUS-1:0] MEM_SH  = 4'd7;
    localparam logic [MEM_OP_BUS-1:0] MEM_SW  = 4'd8;

    localparam logic                    DISABLED      = 1'b0;
    localparam logic [REG_BUS-1:0]      ZERO_WORD     = 32'h0000_0000;
    localparam logic [REG_ADDR_BUS-1:0] NULL_REG_ADDR = 5'b00000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    function automatic logic is_load(input logic [MEM_OP_BUS-1:0] op);
        return (op == MEM_LB) || (op == MEM_LH) || (op == MEM_LW) ||
               (op == MEM_LBU) || (op == MEM_LHU);
    endfunction

    function automatic logic is_store(input logic [MEM_OP_BUS-1:0] op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic is_mem_op(input logic [MEM_OP_BUS-1:0] op);
        return is_load(op) || is_store(op);
    endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Purpose: byte-lane alignment for loads/stores (enables, replicated store data, extended load data).
// Latency: purely combinational.
// Backpressure: none.
// Ports: op/addr_lo select lanes; sdata -> be/wdata for stores; rdata -> ldata for loads.
module mem_align
    import mem_stage_pkg::*;
(
    input  logic [MEM_OP_BUS-1:0] op,
    input  logic [1:0]            addr_lo,
    input  logic [REG_BUS-1:0]    sdata,
    input  logic [REG_BUS-1:0]    rdata,
    output logic [3:0]            be,
    output logic [REG_BUS-1:0]    wdata,
    output logic [REG_BUS-1:0]    ldata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (addr_lo)
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            2'd3:    lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        // halfword lane ignores addr_lo[0]: misaligned halfwords round down
        lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        be    = 4'b0000;
        wdata = ZERO_WORD;
        ldata = ZERO_WORD;
        case (op)
            MEM_LB:  ldata = {{24{lane_b[7]}}, lane_b};
            MEM_LBU: ldata = {24'h0, lane_b};
            MEM_LH:  ldata = {{16{lane_h[15]}}, lane_h};
            MEM_LHU: ldata = {16'h0, lane_h};
            MEM_LW:  ldata = rdata;
            MEM_SB: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{sdata[7:0]}};
            end
            MEM_SH: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{sdata[15:0]}};
            end
            MEM_SW: begin
                be    = 4'b1111;
                wdata = sdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Purpose: MEM pipeline stage; passes ALU results through, runs req/ack data-bus transactions for loads/stores.
// Latency: 0 cycles for non-memory ops; memory ops retire in DONE, 2 cycles after arrival plus bus wait cycles.
// Backpressure: stallreq_mem holds the pipeline while a transaction is pending; stall[3] holds DONE.
// Ports: clk/rst (sync, active low); ex_* from EX/MEM; mem_* to mem_wb; bus_* data-memory bus.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [REG_ADDR_BUS-1:0] ex_wd,
    input  logic                    ex_wreg,
    input  logic [REG_BUS-1:0]      ex_wdata,
    input  logic [MEM_OP_BUS-1:0]   ex_mem_op,
    input  logic [REG_BUS-1:0]      ex_mem_addr,
    input  logic [REG_BUS-1:0]      ex_mem_sdata,
    output logic [REG_ADDR_BUS-1:0] mem_wd,
    output logic                    mem_wreg,
    output logic [REG_BUS-1:0]      mem_wdata,
    output logic                    stallreq_mem,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [REG_BUS-1:0]      bus_addr,
    output logic [3:0]              bus_be,
    output logic [REG_BUS-1:0]      bus_wdata,
    input  logic                    bus_ack,
    input  logic [REG_BUS-1:0]      bus_rdata
);

    mem_state_e         state_q;
    mem_state_e         state_d;
    logic [REG_BUS-1:0] load_q;
    logic [3:0]         align_be;
    logic [REG_BUS-1:0] align_wdata;
    logic [REG_BUS-1:0] align_ldata;
    logic               stall_unused;

    // only the EX/MEM hold bit matters to this stage
    assign stall_unused = ^{stall[5:4], stall[2:0]};

    // ex_* stay stable through BUSY/DONE because the pipeline is held,
    // so the aligner can work directly off the EX/MEM register
    mem_align u_align (
        .op      (ex_mem_op),
        .addr_lo (ex_mem_addr[1:0]),
        .sdata   (ex_mem_sdata),
        .rdata   (bus_rdata),
        .be      (align_be),
        .wdata   (align_wdata),
        .ldata   (align_ldata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= ZERO_WORD;
            bus_be    <= 4'b0000;
            bus_wdata <= ZERO_WORD;
            load_q    <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && is_mem_op(ex_mem_op)) begin
                bus_req   <= 1'b1;
                bus_we    <= is_store(ex_mem_op);
                bus_addr  <= {ex_mem_addr[31:2], 2'b00};
                bus_be    <= align_be;
                bus_wdata <= align_wdata;
            end
            if (state_q == ST_BUSY && bus_ack) begin
                bus_req <= 1'b0;
                load_q  <= align_ldata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (is_mem_op(ex_mem_op)) state_d = ST_BUSY;
            ST_BUSY: if (bus_ack)              state_d = ST_DONE;
            ST_DONE: if (!stall[3])            state_d = ST_IDLE;
            default:                           state_d = ST_IDLE;
        endcase
    end

    // outputs are forced to their reset values while rst is low so that
    // a combinational pass-through cannot leak stale EX data during reset
    always_comb begin
        mem_wd       = NULL_REG_ADDR;
        mem_wreg     = DISABLED;
        mem_wdata    = ZERO_WORD;
        stallreq_mem = 1'b0;
        if (rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (is_mem_op(ex_mem_op)) begin
                        stallreq_mem = 1'b1;
                    end else begin
                        mem_wd    = ex_wd;
                        mem_wreg  = ex_wreg;
                        mem_wdata = ex_wdata;
                    end
                end
                ST_BUSY: stallreq_mem = 1'b1;
                ST_DONE: begin
                    mem_wd = ex_wd;
                    if (is_load(ex_mem_op)) begin
                        mem_wreg  = ex_wreg;
                        mem_wdata = load_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [3:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_sdata;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        stallreq_mem;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .ex_wd        (ex_wd),
        .ex_wreg      (ex_wreg),
        .ex_wdata     (ex_wdata),
        .ex_mem_op    (ex_mem_op),
        .ex_mem_addr  (ex_mem_addr),
        .ex_mem_sdata (ex_mem_sdata),
        .mem_wd       (mem_wd),
        .mem_wreg     (mem_wreg),
        .mem_wdata    (mem_wdata),
        .stallreq_mem (stallreq_mem),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_be       (bus_be),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    typedef struct {
        string       name;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    logic issuing = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a retirement is any cycle mem_wb captures (not stalled, not in reset).
    always @(negedge clk) begin
        exp_t e;
        if (issuing && rst === 1'b1 && stall[3] === 1'b0 && stallreq_mem === 1'b0) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL retire_unexpected: got wd=%0d wreg=%b wdata=%h expected no retirement",
                         mem_wd, mem_wreg, mem_wdata);
            end else begin
                e = sb_q.pop_front();
                check32({e.name, "_wreg"}, {31'b0, mem_wreg}, {31'b0, e.wreg});
                if (e.wreg) begin
                    check32({e.name, "_wd"}, {27'b0, mem_wd}, {27'b0, e.wd});
                    check32({e.name, "_wdata"}, mem_wdata, e.wdata);
                end
            end
        end
    end

    // Driver: applies one instruction at posedge+1 and returns at posedge+1 after it retires.
    task automatic run_op(input string name, input logic [3:0] op, input logic [4:0] wd,
                          input logic wreg, input logic [31:0] wdata, input logic [31:0] addr,
                          input logic [31:0] sdata, input int waits, input logic [31:0] rdata,
                          input logic exp_wreg, input logic [31:0] exp_wdata, input logic exp_we,
                          input logic [3:0] exp_be, input logic [31:0] exp_baddr,
                          input logic [31:0] exp_bwdata, input int hold);
        exp_t e;
        int   stall_cnt;
        e.name = name; e.wd = wd; e.wreg = exp_wreg; e.wdata = exp_wdata;
        sb_q.push_back(e);
        ex_mem_op = op; ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_mem_addr = addr; ex_mem_sdata = sdata;
        issuing = 1'b1;
        if (op == MEM_NOP) begin
            @(negedge clk);
            check32({name, "_stallreq"}, {31'b0, stallreq_mem}, 32'd0);
            check32({name, "_busreq"}, {31'b0, bus_req}, 32'd0);
            @(posedge clk); #1;
        end else begin
            stall_cnt = 0;
            @(negedge clk);
            if (stallreq_mem) stall_cnt++;
            check32({name, "_idle_wreg"}, {31'b0, mem_wreg}, 32'd0);
            @(posedge clk); #1;
            for (int k = 0; k <= waits; k++) begin
                bus_ack   = (k == waits);
                bus_rdata = (k == waits) ? rdata : 32'h5A5A_5A5A;
                @(negedge clk);
                if (stallreq_mem) stall_cnt++;
                check32({name, "_busy_req"}, {31'b0, bus_req}, 32'd1);
                check32({name, "_busy_addr"}, bus_addr, exp_baddr);
                if (k == 0) begin
                    check32({name, "_we"}, {31'b0, bus_we}, {31'b0, exp_we});
                    check32({name, "_be"}, {28'b0, bus_be}, {28'b0, exp_be});
                    check32({name, "_bwdata"}, bus_wdata, exp_bwdata);
                    check32({name, "_busy_wreg"}, {31'b0, mem_wreg}, 32'd0);
                end
                @(posedge clk); #1;
            end
            bus_ack = 1'b0;
            bus_rdata = 32'h0;
            if (hold > 0) stall = 6'b001000;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check32({name, "_hold_stallreq"}, {31'b0, stallreq_mem}, 32'd0);
                check32({name, "_hold_busreq"}, {31'b0, bus_req}, 32'd0);
                check32({name, "_hold_wreg"}, {31'b0, mem_wreg}, {31'b0, exp_wreg});
                check32({name, "_hold_wdata"}, mem_wdata, exp_wdata);
                @(posedge clk); #1;
            end
            stall = 6'b000000;
            @(negedge clk);
            if (stallreq_mem) stall_cnt++;
            check32({name, "_stall_cycles"}, stall_cnt, waits + 2);
            check32({name, "_done_busreq"}, {31'b0, bus_req}, 32'd0);
            @(posedge clk); #1;
        end
        issuing = 1'b0;
    endtask

    initial begin
        rst = 1'b0; stall = 6'b0; bus_ack = 1'b0; bus_rdata = 32'h0;
        // memory op on the inputs during reset: outputs must still read as reset values
        ex_mem_op = MEM_LW; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hFFFF_FFFF;
        ex_mem_addr = 32'h1234_5678; ex_mem_sdata = 32'hFFFF_FFFF;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        check32("rst_mem_wd", {27'b0, mem_wd}, 32'd0);
        check32("rst_mem_wreg", {31'b0, mem_wreg}, 32'd0);
        check32("rst_mem_wdata", mem_wdata, 32'd0);
        check32("rst_stallreq", {31'b0, stallreq_mem}, 32'd0);
        check32("rst_bus_req", {31'b0, bus_req}, 32'd0);
        check32("rst_bus_we", {31'b0, bus_we}, 32'd0);
        check32("rst_bus_addr", bus_addr, 32'd0);
        check32("rst_bus_be", {28'b0, bus_be}, 32'd0);
        check32("rst_bus_wdata", bus_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        ex_mem_op = MEM_NOP;

        //     name    op       wd    wreg  wdata         addr          sdata         w  rdata         ewreg ewdata        we    be       baddr         bwdata        hold
        run_op("add",  MEM_NOP, 5'd5, 1'b1, 32'h0000_1234, 32'h0,        32'h0,        0, 32'h0,        1'b1, 32'h0000_1234, 1'b0, 4'b0000, 32'h0,        32'h0,        0);
        run_op("lb",   MEM_LB,  5'd6, 1'b1, 32'hEEEE_EEEE, 32'h0000_1003, 32'h0,        2, 32'h80FF_FF7F, 1'b1, 32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0000_1000, 32'h0,        0);
        run_op("lhu",  MEM_LHU, 5'd7, 1'b1, 32'hEEEE_EEEE, 32'h0000_2002, 32'h0,        0, 32'hBEEF_0000, 1'b1, 32'h0000_BEEF, 1'b0, 4'b0000, 32'h0000_2000, 32'h0,        0);
        run_op("sb",   MEM_SB,  5'd0, 1'b0, 32'hEEEE_EEEE, 32'h0000_3001, 32'h0000_00AB, 0, 32'h0,        1'b0, 32'h0,        1'b1, 4'b0010, 32'h0000_3000, 32'hABAB_ABAB, 0);
        run_op("lw_h", MEM_LW,  5'd8, 1'b1, 32'hEEEE_EEEE, 32'h0000_4005, 32'h0,        1, 32'h1122_3344, 1'b1, 32'h1122_3344, 1'b0, 4'b0000, 32'h0000_4004, 32'h0,        2);
        run_op("nop2", MEM_NOP, 5'd2, 1'b1, 32'hCAFE_0001, 32'h0,        32'h0,        0, 32'h0,        1'b1, 32'hCAFE_0001, 1'b0, 4'b0000, 32'h0,        32'h0,        0);
        run_op("lh",   MEM_LH,  5'd11,1'b1, 32'hEEEE_EEEE, 32'h0000_5003, 32'h0,        0, 32'h8001_7FFF, 1'b1, 32'hFFFF_8001, 1'b0, 4'b0000, 32'h0000_5000, 32'h0,        0);
        run_op("sh",   MEM_SH,  5'd0, 1'b0, 32'hEEEE_EEEE, 32'h0000_6003, 32'h1234_CAFE, 1, 32'h0,        1'b0, 32'h0,        1'b1, 4'b1100, 32'h0000_6000, 32'hCAFE_CAFE, 1);
        run_op("sw",   MEM_SW,  5'd0, 1'b0, 32'hEEEE_EEEE, 32'h0000_7002, 32'hDEAD_BEEF, 0, 32'h0,        1'b0, 32'h0,        1'b1, 4'b1111, 32'h0000_7000, 32'hDEAD_BEEF, 0);
        run_op("lbu",  MEM_LBU, 5'd12,1'b1, 32'hEEEE_EEEE, 32'h0000_8002, 32'h0,        0, 32'h0080_0000, 1'b1, 32'h0000_0080, 1'b0, 4'b0000, 32'h0000_8000, 32'h0,        0);
        run_op("lb_p", MEM_LB,  5'd13,1'b1, 32'hEEEE_EEEE, 32'h0000_9000, 32'h0,        0, 32'h1234_567F, 1'b1, 32'h0000_007F, 1'b0, 4'b0000, 32'h0000_9000, 32'h0,        0);

        // reset while a load is outstanding
        ex_mem_op = MEM_LW; ex_wd = 5'd10; ex_wreg = 1'b1; ex_wdata = 32'hEEEE_EEEE;
        ex_mem_addr = 32'h0000_A000; ex_mem_sdata = 32'h0;
        @(posedge clk); #1;
        @(negedge clk);
        check32("rb_busy_req", {31'b0, bus_req}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        check32("rb_bus_req", {31'b0, bus_req}, 32'd0);
        check32("rb_stallreq", {31'b0, stallreq_mem}, 32'd0);
        check32("rb_mem_wreg", {31'b0, mem_wreg}, 32'd0);
        check32("rb_mem_wd", {27'b0, mem_wd}, 32'd0);
        check32("rb_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        // stray ack stays high while idle; stage must remain a pass-through
        run_op("rb_nop",  MEM_NOP, 5'd3, 1'b1, 32'h0000_0055, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h0000_0055, 1'b0, 4'b0000, 32'h0, 32'h0, 0);
        bus_ack = 1'b0;
        run_op("rb_nop2", MEM_NOP, 5'd4, 1'b1, 32'h0000_0066, 32'h0, 32'h0, 0, 32'h0, 1'b1, 32'h0000_0066, 1'b0, 4'b0000, 32'h0, 32'h0, 0);
        run_op("rb_lw",   MEM_LW,  5'd14,1'b1, 32'hEEEE_EEEE, 32'h0000_B000, 32'h0, 0, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b0, 4'b0000, 32'h0000_B000, 32'h0, 0);

        ex_mem_op = MEM_NOP;
        repeat (2) @(negedge clk);
        check32("sb_drain", sb_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
